// File: rtl/paddle_pkg.sv
// Shared encodings and default geometry for the paddle engine and its neighbours.
package paddle_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'b11;
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        FLUSH = 2'b10
    } draw_state_t;

    localparam int DEF_SCREEN_W  = 160;
    localparam int DEF_PADDLE_Y  = 167;
    localparam int DEF_MAX_W     = 40;
    localparam int DEF_MIN_W     = 16;
    localparam int DEF_STEP_W    = 8;
    localparam int DEF_H         = 8;
    localparam int DEF_TICK_DIV  = 1000000;
    localparam int DEF_MAX_SPEED = 3;
    localparam int DEF_MEM_LAT   = 1;
    localparam int DEF_ADDR_W    = 11;

endpackage

// File: rtl/paddle_engine_if.sv
// Control inputs, paddle state and pixel stream of the paddle engine.
interface paddle_engine_if #(
    parameter int ADDR_W = paddle_pkg::DEF_ADDR_W
);
    logic [1:0]        move_dir;
    logic              grow;
    logic              shrink;
    logic              draw_start;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [7:0]        width;
    logic              busy;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        draw_x;
    logic [7:0]        draw_y;
    logic              draw_valid;
    logic              draw_done;

    modport master (
        output move_dir, grow, shrink, draw_start,
        input  x, y, width, busy, pix_addr, draw_x, draw_y, draw_valid, draw_done
    );

    modport slave (
        input  move_dir, grow, shrink, draw_start,
        output x, y, width, busy, pix_addr, draw_x, draw_y, draw_valid, draw_done
    );
endinterface

// File: rtl/tick_gen.sv
// Clock divider: one-cycle tick each time the counter wraps from DIV-1 to 0.
module tick_gen #(
    parameter int DIV = 1000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered wrap pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == CW'(DIV - 1)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/paddle_engine.sv
// Paddle movement with acceleration, run-time width change and a ROM-aligned pixel scan.
module paddle_engine
    import paddle_pkg::*;
#(
    parameter int SCREEN_W  = DEF_SCREEN_W,
    parameter int PADDLE_Y  = DEF_PADDLE_Y,
    parameter int MAX_W     = DEF_MAX_W,
    parameter int MIN_W     = DEF_MIN_W,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int H         = DEF_H,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int MAX_SPEED = DEF_MAX_SPEED,
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input logic            clk,
    input logic            reset,
    paddle_engine_if.slave bus
);
    logic              tick_s;
    logic [7:0]        x_r, width_r, speed_r;
    logic [1:0]        prev_dir_r;
    logic [7:0]        w_next_s, spd_next_s, x_next_s;
    logic [1:0]        dir_next_s;
    logic signed [8:0] x_max_s, x_base_s, x_cand_s;

    draw_state_t       state_r;
    logic [7:0]        lx_r, lw_r, cx_r, cy_r, flush_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        s0_x_r, s0_y_r;
    logic              s0_v_r, busy_r, done_r;
    logic [7:0]        dx_r [MEM_LAT];
    logic [7:0]        dy_r [MEM_LAT];
    logic              dv_r [MEM_LAT];

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Next width, speed and position; width settles first so movement clamps to it
    always_comb begin
        w_next_s   = width_r;
        spd_next_s = speed_r;
        dir_next_s = prev_dir_r;
        if (bus.grow && !bus.shrink) begin
            w_next_s = (width_r >= 8'(MAX_W - STEP_W)) ? 8'(MAX_W) : width_r + 8'(STEP_W);
        end else if (bus.shrink && !bus.grow) begin
            w_next_s = (width_r <= 8'(MIN_W + STEP_W)) ? 8'(MIN_W) : width_r - 8'(STEP_W);
        end else begin
            w_next_s = width_r;
        end
        if (tick_s) begin
            dir_next_s = bus.move_dir;
            if ((bus.move_dir == DIR_LEFT) || (bus.move_dir == DIR_RIGHT)) begin
                if (bus.move_dir != prev_dir_r) begin
                    spd_next_s = 8'd1;
                end else if (speed_r >= 8'(MAX_SPEED)) begin
                    spd_next_s = 8'(MAX_SPEED);
                end else begin
                    spd_next_s = speed_r + 8'd1;
                end
            end else begin
                spd_next_s = 8'd0;
            end
        end else begin
            dir_next_s = prev_dir_r;
            spd_next_s = speed_r;
        end
        // Signed 9-bit so a left step past zero goes negative instead of wrapping
        x_max_s  = $signed(9'(SCREEN_W)) - $signed({1'b0, w_next_s});
        x_base_s = ($signed({1'b0, x_r}) > x_max_s) ? x_max_s : $signed({1'b0, x_r});
        if (tick_s && (bus.move_dir == DIR_RIGHT)) begin
            x_cand_s = x_base_s + $signed({1'b0, spd_next_s});
        end else if (tick_s && (bus.move_dir == DIR_LEFT)) begin
            x_cand_s = x_base_s - $signed({1'b0, spd_next_s});
        end else begin
            x_cand_s = x_base_s;
        end
        if (x_cand_s < 9'sd0) begin
            x_next_s = 8'd0;
        end else if (x_cand_s > x_max_s) begin
            x_next_s = x_max_s[7:0];
        end else begin
            x_next_s = x_cand_s[7:0];
        end
    end

    // Paddle state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r        <= 8'((SCREEN_W - MAX_W) / 2);
            width_r    <= 8'(MAX_W);
            speed_r    <= 8'd0;
            prev_dir_r <= 2'b00;
        end else begin
            x_r        <= x_next_s;
            width_r    <= w_next_s;
            speed_r    <= spd_next_s;
            prev_dir_r <= dir_next_s;
        end
    end

    // Draw scan FSM: pixel (0,0) is issued on the start edge, the rest one per cycle in SCAN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            lx_r    <= 8'd0;
            lw_r    <= 8'd0;
            cx_r    <= 8'd0;
            cy_r    <= 8'd0;
            flush_r <= 8'd0;
            addr_r  <= '0;
            s0_x_r  <= 8'd0;
            s0_y_r  <= 8'd0;
            s0_v_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            s0_v_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.draw_start) begin
                        lx_r    <= x_r;
                        lw_r    <= width_r;
                        cx_r    <= 8'd1;
                        cy_r    <= 8'd0;
                        addr_r  <= '0;
                        s0_x_r  <= x_r;
                        s0_y_r  <= 8'(PADDLE_Y);
                        s0_v_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= SCAN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    addr_r <= ADDR_W'(cy_r) * ADDR_W'(MAX_W) + ADDR_W'(cx_r);
                    s0_x_r <= lx_r + cx_r;
                    s0_y_r <= 8'(PADDLE_Y) + cy_r;
                    s0_v_r <= 1'b1;
                    if (cx_r == lw_r - 8'd1) begin
                        cx_r <= 8'd0;
                        if (cy_r == 8'(H - 1)) begin
                            flush_r <= 8'd0;
                            state_r <= FLUSH;
                        end else begin
                            cy_r <= cy_r + 8'd1;
                        end
                    end else begin
                        cx_r <= cx_r + 8'd1;
                    end
                end
                FLUSH: begin
                    if (flush_r == 8'(MEM_LAT)) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        flush_r <= flush_r + 8'd1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Coordinate delay line matching the sprite ROM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                dx_r[i] <= 8'd0;
                dy_r[i] <= 8'd0;
                dv_r[i] <= 1'b0;
            end
        end else begin
            dx_r[0] <= s0_x_r;
            dy_r[0] <= s0_y_r;
            dv_r[0] <= s0_v_r;
            for (int i = 1; i < MEM_LAT; i++) begin
                dx_r[i] <= dx_r[i-1];
                dy_r[i] <= dy_r[i-1];
                dv_r[i] <= dv_r[i-1];
            end
        end
    end

    assign bus.x          = x_r;
    assign bus.y          = 8'(PADDLE_Y);
    assign bus.width      = width_r;
    assign bus.busy       = busy_r;
    assign bus.pix_addr   = addr_r;
    assign bus.draw_x     = dx_r[MEM_LAT-1];
    assign bus.draw_y     = dy_r[MEM_LAT-1];
    assign bus.draw_valid = dv_r[MEM_LAT-1];
    assign bus.draw_done  = done_r;
endmodule

// File: tb/tb_paddle_engine.sv
// Directed bench: movement/width model checks plus a scoreboard of expected scan pixels.
module tb_paddle_engine;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   nvalid;
    int   ex, ew, espd;
    logic [1:0]  eprev;
    logic [15:0] exp_q [$];
    logic [15:0] e_pix;

    paddle_engine_if #(.ADDR_W(11)) bus ();

    paddle_engine #(.TICK_DIV(4), .MEM_LAT(1), .ADDR_W(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference movement: speed rule then clamp against the current width
    task automatic model_tick(input logic [1:0] d);
        if ((d == 2'b11) || (d == 2'b01)) begin
            if (d == eprev) espd = (espd >= 3) ? 3 : espd + 1;
            else espd = 1;
        end else begin
            espd = 0;
        end
        eprev = d;
        if (d == 2'b01) ex = ex + espd;
        else if (d == 2'b11) ex = ex - espd;
        if (ex < 0) ex = 0;
        if (ex > 160 - ew) ex = 160 - ew;
    endtask

    task automatic tick_check(input logic [1:0] d, input string tag);
        bus.move_dir = d;
        step(4);
        model_tick(d);
        chk(bus.x, ex, tag);
    endtask

    task automatic cmd(input logic g, input logic s, input string tag);
        bus.grow = g;
        bus.shrink = s;
        step(1);
        bus.grow = 1'b0;
        bus.shrink = 1'b0;
        if (g && !s) ew = (ew + 8 > 40) ? 40 : ew + 8;
        if (s && !g) ew = (ew - 8 < 16) ? 16 : ew - 8;
        if (ex > 160 - ew) ex = 160 - ew;
        step(3);
        model_tick(bus.move_dir);
        chk(bus.width, ew, {tag, "_w"});
        chk(bus.x, ex, {tag, "_x"});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        ex = 60; ew = 40; espd = 0; eprev = 2'b00;
    endtask

    task automatic start_scan(input int lx, input int lw);
        for (int cy = 0; cy < 8; cy++)
            for (int cx = 0; cx < lw; cx++)
                exp_q.push_back({8'(167 + cy), 8'(lx + cx)});
        nvalid = 0;
        bus.draw_start = 1'b1;
        step(1);
        bus.draw_start = 1'b0;
        chk(bus.busy, 1, "busy_on");
        chk(bus.pix_addr, 0, "addr_first");
        chk(bus.draw_valid, 0, "valid_latency");
    endtask

    task automatic finish_scan(input int inject_k);
        logic prev_v;
        int   done_k;
        prev_v = 1'b0;
        done_k = 0;
        for (int k = 2; k <= 400; k++) begin
            if (k == inject_k) bus.draw_start = 1'b1;
            step(1);
            bus.draw_start = 1'b0;
            if (k == 2) begin
                chk(bus.draw_valid, 1, "first_valid");
                chk({bus.draw_y, bus.draw_x}, {8'd167, 8'd60}, "first_xy");
            end
            if (k <= 320) chk(bus.pix_addr, k - 1, "addr_seq");
            if (bus.draw_done === 1'b1) begin
                done_k = k;
                chk(prev_v, 1, "done_after_last_valid");
                chk(bus.draw_valid, 0, "valid_off_at_done");
                break;
            end
            prev_v = bus.draw_valid;
        end
        chk(done_k, 322, "done_cycle");
        chk(nvalid, 320, "valid_count");
        chk(exp_q.size(), 0, "queue_drained");
        step(1);
        chk(bus.draw_done, 0, "done_one_cycle");
        chk(bus.busy, 0, "busy_off");
    endtask

    // Scoreboard: every valid pixel must match the next expected coordinate
    always @(negedge clk) begin
        if (bus.draw_valid === 1'b1) begin
            nvalid++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL draw_extra observed=%0d,%0d expected=none", bus.draw_x, bus.draw_y);
            end else begin
                e_pix = exp_q.pop_front();
                chk({bus.draw_y, bus.draw_x}, e_pix, "draw_xy");
            end
        end
    end

    initial begin
        clk = 1'b0;
        checks = 0;
        errors = 0;
        nvalid = 0;
        bus.move_dir = 2'b00;
        bus.grow = 1'b0;
        bus.shrink = 1'b0;
        bus.draw_start = 1'b0;
        reset = 1'b1;
        step(2);
        chk(bus.x, 60, "rst_x");
        chk(bus.y, 167, "rst_y");
        chk(bus.width, 40, "rst_width");
        chk(bus.busy, 0, "rst_busy");
        chk(bus.draw_valid, 0, "rst_valid");
        chk(bus.pix_addr, 0, "rst_addr");
        do_reset();
        step(2);

        for (int i = 0; i < 5; i++) tick_check(2'b01, "accel_right");
        chk(bus.x, 72, "accel_end");
        tick_check(2'b11, "reverse_left");
        chk(bus.x, 71, "reverse_x");
        tick_check(2'b10, "stop_hold");
        tick_check(2'b10, "stop_hold");
        for (int i = 0; i < 20; i++) tick_check(2'b01, "clamp_right");
        chk(bus.x, 120, "clamp_right_end");

        bus.move_dir = 2'b10;
        cmd(1'b0, 1'b1, "shrink_at_edge");
        cmd(1'b1, 1'b0, "grow_at_edge");
        cmd(1'b1, 1'b0, "grow_saturate");
        for (int i = 0; i < 4; i++) cmd(1'b0, 1'b1, "shrink_seq");
        chk(bus.width, 16, "shrink_min");
        cmd(1'b1, 1'b1, "grow_and_shrink");
        for (int i = 0; i < 10; i++) tick_check(2'b01, "narrow_right");
        chk(bus.x, 144, "narrow_clamp");
        cmd(1'b1, 1'b0, "grow_pushes_left");
        for (int i = 0; i < 50; i++) tick_check(2'b11, "clamp_left");
        chk(bus.x, 0, "clamp_left_end");

        do_reset();
        bus.move_dir = 2'b01;
        start_scan(60, 40);
        finish_scan(50);

        bus.move_dir = 2'b10;
        do_reset();
        start_scan(60, 40);
        for (int k = 2; k <= 101; k++) step(1);
        chk(bus.pix_addr, 100, "abort_addr");
        reset = 1'b1;
        step(1);
        exp_q.delete();
        chk(bus.busy, 0, "abort_busy");
        chk(bus.draw_valid, 0, "abort_valid");
        chk(bus.draw_done, 0, "abort_done");
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk(bus.draw_done, 0, "abort_no_done");
        end
        start_scan(60, 40);
        finish_scan(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
